// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hilo_muldiv_unit_if                                            |
// | Purpose  : Request/response bundle for the HI/LO multiply-divide unit.    |
// |            master : requester (drives Start/Op/A/B, observes results)     |
// |            slave  : the unit itself                                      |
// | Signals  : Start, Op[3:0], A, B           (requester -> unit)             |
// |            Busy, Done, DivByZero,                                        |
// |            HI_out, LO_out                 (unit -> requester)             |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivByZero, HI_out, LO_out
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivByZero, HI_out, LO_out
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hilo_muldiv_unit                                               |
// | Purpose  : MIPS-style HI/LO unit. Iterative radix-2 shift-add multiply    |
// |            and restoring divide, WIDTH steps each, plus mthi/mtlo.        |
// | Ports    : Clk        - clock, rising edge                                |
// |            Reset      - asynchronous, active-low                          |
// |            bus.Start  - request, accepted only in IDLE                    |
// |            bus.Op     - 0 mult,1 multu,2 madd,3 msub,4 div,5 divu,        |
// |                         6 mthi,7 mtlo; anything else ignored             |
// |            bus.A/B    - operands, sampled at acceptance only              |
// |            bus.Busy   - MUL/DIV/FIX in progress                           |
// |            bus.Done   - one-cycle completion pulse                        |
// |            bus.DivByZero - with Done, for div/divu by zero               |
// |            bus.HI_out/LO_out - architectural HI/LO                       |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int SIGNED_FIX = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  hilo_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_MUL  = 3'd1;
  localparam logic [2:0] c_DIV  = 3'd2;
  localparam logic [2:0] c_FIX  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [3:0] c_OP_MULT  = 4'b0000;
  localparam logic [3:0] c_OP_MULTU = 4'b0001;
  localparam logic [3:0] c_OP_MADD  = 4'b0010;
  localparam logic [3:0] c_OP_MSUB  = 4'b0011;
  localparam logic [3:0] c_OP_DIV   = 4'b0100;
  localparam logic [3:0] c_OP_DIVU  = 4'b0101;
  localparam logic [3:0] c_OP_MTHI  = 4'b0110;
  localparam logic [3:0] c_OP_MTLO  = 4'b0111;

  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;   // multiplicand or divisor magnitude
  logic               r_neg_q;   // negate product / quotient in FIX
  logic               r_neg_r;   // negate remainder in FIX
  logic [3:0]         r_op;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // ---------------- request decode ----------------
  logic w_signed_op;
  logic w_legal;
  logic w_accept;
  logic w_is_div;
  logic w_sgn;

  assign w_signed_op = (bus.Op == c_OP_MULT) || (bus.Op == c_OP_MADD) ||
                       (bus.Op == c_OP_MSUB) || (bus.Op == c_OP_DIV);
  assign w_legal     = (bus.Op <= c_OP_MTLO) && ((SIGNED_FIX != 0) || !w_signed_op);
  assign w_accept    = bus.Start && (r_state == c_IDLE) && w_legal;
  assign w_is_div    = (bus.Op == c_OP_DIV) || (bus.Op == c_OP_DIVU);
  assign w_sgn       = w_signed_op;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  assign w_a_mag = (w_sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign w_b_mag = (w_sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring step: trial-subtract the divisor from the remainder shifted
  // left by one; a clear borrow bit means the subtraction stands.
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_div_shift = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
  assign w_div_next  = {(w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0]),
                        r_prod[WIDTH-2:0], ~w_div_diff[WIDTH]};

  // ---------------- sign fix / write-back ----------------
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [2*WIDTH-1:0] w_fix_hilo;
  assign w_prod_s = r_neg_q ? -r_prod : r_prod;
  assign w_quot_s = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_s  = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hilo = w_prod_s;
    case (r_op)
      c_OP_MADD: w_fix_hilo = {r_hi, r_lo} + w_prod_s;
      c_OP_MSUB: w_fix_hilo = {r_hi, r_lo} - w_prod_s;
      c_OP_DIV,
      c_OP_DIVU: w_fix_hilo = {w_rem_s, w_quot_s};
      default:   w_fix_hilo = w_prod_s;
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_op    <= '0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.Op;
            r_cnt <= '0;
            if (bus.Op == c_OP_MTHI) begin
              r_hi    <= bus.A;
              r_state <= c_DONE;
            end else if (bus.Op == c_OP_MTLO) begin
              r_lo    <= bus.A;
              r_state <= c_DONE;
            end else if (w_is_div) begin
              if (bus.B == '0) begin
                r_dbz   <= 1'b1;
                r_state <= c_DONE;
              end else begin
                r_prod  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mcand <= w_b_mag;
                r_neg_q <= w_sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                r_neg_r <= w_sgn & bus.A[WIDTH-1];
                r_state <= c_DIV;
              end
            end else begin
              r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
              r_mcand <= w_a_mag;
              r_neg_q <= w_sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              r_neg_r <= 1'b0;
              r_state <= c_MUL;
            end
          end
        end
        c_MUL: begin
          r_prod <= w_mul_next;
          if (r_cnt == c_LAST) r_state <= c_FIX;
          else                 r_cnt   <= r_cnt + 1'b1;
        end
        c_DIV: begin
          r_prod <= w_div_next;
          if (r_cnt == c_LAST) r_state <= c_FIX;
          else                 r_cnt   <= r_cnt + 1'b1;
        end
        c_FIX: begin
          r_hi    <= w_fix_hilo[2*WIDTH-1:WIDTH];
          r_lo    <= w_fix_hilo[WIDTH-1:0];
          r_state <= c_DONE;
        end
        c_DONE: begin
          r_dbz   <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.Busy      = (r_state == c_MUL) || (r_state == c_DIV) || (r_state == c_FIX);
  assign bus.Done      = (r_state == c_DONE);
  assign bus.DivByZero = r_dbz;
  assign bus.HI_out    = r_hi;
  assign bus.LO_out    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hilo_muldiv_unit                                            |
// | Purpose  : Scoreboard bench for hilo_muldiv_unit (WIDTH=32). Stimulus     |
// |            computes expected HI/LO with 64-bit arithmetic and queues it;  |
// |            a negedge monitor pops on every Done and compares.            |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_hilo_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  hilo_muldiv_unit_if #(.WIDTH(WIDTH)) dut_if ();

  hilo_muldiv_unit #(.WIDTH(WIDTH), .SIGNED_FIX(1)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          done_at;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          pcnt  = 0;
  int          busy_run = 0;
  logic [31:0] m_hi = '0, m_lo = '0;     // model state at issue time
  logic [31:0] cur_hi = '0, cur_lo = '0; // last committed value seen by monitor

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dut_if.Busy) begin
        busy_run++;
        if (sb.size() == 0) check("busy_without_op", 1, 0);
        check("hilo_hold_while_busy", {dut_if.HI_out, dut_if.LO_out}, {cur_hi, cur_lo});
      end
      if (dut_if.DivByZero && !dut_if.Done) check("dbz_without_done", 1, 0);
      if (dut_if.Done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("HI", {32'd0, dut_if.HI_out}, {32'd0, e.hi});
          check("LO", {32'd0, dut_if.LO_out}, {32'd0, e.lo});
          check("DivByZero", {63'd0, dut_if.DivByZero}, {63'd0, e.dbz});
          check("done_latency", 64'(pcnt), 64'(e.done_at));
          check("busy_cycles", 64'(busy_run), 64'(e.busy));
          check("busy_low_in_done", {63'd0, dut_if.Busy}, 64'd0);
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
        busy_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
    exp_t        e;
    logic [63:0] hl, qq, rr;
    longint      sa, sbv;
    bit          dbz, longop;
    @(posedge clk); #1;
    hl  = {m_hi, m_lo};
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    dbz = 1'b0;
    case (op)
      4'd0: hl = sa * sbv;
      4'd1: hl = {32'd0, a} * {32'd0, b};
      4'd2: hl = hl + 64'(sa * sbv);
      4'd3: hl = hl - 64'(sa * sbv);
      4'd4: if (b == 0) dbz = 1'b1;
            else begin qq = sa / sbv; rr = sa % sbv; hl = {rr[31:0], qq[31:0]}; end
      4'd5: if (b == 0) dbz = 1'b1;
            else begin qq = {32'd0, a} / {32'd0, b}; rr = {32'd0, a} % {32'd0, b};
                       hl = {rr[31:0], qq[31:0]}; end
      4'd6: hl[63:32] = a;
      4'd7: hl[31:0]  = a;
      default: ;
    endcase
    longop = (op <= 4'd5) && !dbz;
    dut_if.Start = 1'b1;
    dut_if.Op    = op;
    dut_if.A     = a;
    dut_if.B     = b;
    if (op <= 4'd7) begin
      e.hi = hl[63:32]; e.lo = hl[31:0]; e.dbz = dbz;
      e.done_at = pcnt + (longop ? WIDTH + 2 : 1);
      e.busy    = longop ? WIDTH + 1 : 0;
      sb.push_back(e);
      m_hi = hl[63:32];
      m_lo = hl[31:0];
    end
    @(posedge clk); #1;
    dut_if.Start = 1'b0;
    dut_if.A = $urandom;
    dut_if.B = $urandom;
    if (noise && longop) begin
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        dut_if.Start = 1'b1;
        dut_if.Op    = 4'($urandom_range(0, 7));
        dut_if.A     = $urandom;
        dut_if.B     = $urandom;
      end
      @(posedge clk); #1;
      dut_if.Start = 1'b0;
    end
    if (op > 4'd7) begin
      repeat (3) @(posedge clk);
      #1;
      check("illegal_busy", {63'd0, dut_if.Busy}, 64'd0);
      check("illegal_hilo", {dut_if.HI_out, dut_if.LO_out}, {m_hi, m_lo});
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("wait_done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    rst_n = 1'b0;
    dut_if.Start = 1'b0;
    dut_if.Op = '0;
    dut_if.A = '0;
    dut_if.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {dut_if.HI_out, dut_if.LO_out}, 64'd0);
    check("reset_busy_done_dbz", {61'd0, dut_if.Busy, dut_if.Done, dut_if.DivByZero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mult 2000000000 * -7 with mid-op Start and operand changes
    issue(4'd0, 32'd2000000000, -32'sd7, 1'b1);
    wait_idle();
    check("mult_vec", {dut_if.HI_out, dut_if.LO_out}, 64'hFFFF_FFFC_BD88_F400);

    // madd / msub with preload
    issue(4'd6, 32'd12, 32'd0, 1'b0); wait_idle();
    issue(4'd7, 32'd1, 32'd0, 1'b0);  wait_idle();
    issue(4'd2, 32'd3, -32'sd4, 1'b0); wait_idle();
    check("madd_vec", {dut_if.HI_out, dut_if.LO_out}, 64'h0000_000B_FFFF_FFF5);
    issue(4'd6, 32'd12, 32'd0, 1'b0); wait_idle();
    issue(4'd7, 32'd1, 32'd0, 1'b0);  wait_idle();
    issue(4'd3, 32'd3, 32'd4, 1'b0);  wait_idle();
    check("msub_vec", {dut_if.HI_out, dut_if.LO_out}, 64'h0000_000B_FFFF_FFF5);

    // divide vectors
    issue(4'd4, -32'sd7, 32'd2, 1'b0); wait_idle();
    check("div_vec", {dut_if.HI_out, dut_if.LO_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd5, 32'hFFFF_FFFF, 32'd16, 1'b0); wait_idle();
    check("divu_vec", {dut_if.HI_out, dut_if.LO_out}, 64'h0000_000F_0FFF_FFFF);
    issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    check("div_ovf_vec", {dut_if.HI_out, dut_if.LO_out}, 64'h0000_0000_8000_0000);

    // divide by zero keeps HI/LO
    issue(4'd6, 32'hAA, 32'd0, 1'b0); wait_idle();
    issue(4'd7, 32'hBB, 32'd0, 1'b0); wait_idle();
    issue(4'd4, 32'd5, 32'd0, 1'b0);  wait_idle();
    check("div0_vec", {dut_if.HI_out, dut_if.LO_out}, {32'hAA, 32'hBB});

    // illegal op, then back-to-back mults
    issue(4'hF, 32'd9, 32'd9, 1'b0);
    issue(4'd1, 32'd123456, 32'd654321, 1'b0); wait_idle();
    issue(4'd0, -32'sd5, 32'd77, 1'b0); wait_idle();

    // reset mid-multiply
    issue(4'd6, 32'h55, 32'd0, 1'b0); wait_idle();
    issue(4'd0, 32'd1000, 32'd1000, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hilo", {dut_if.HI_out, dut_if.LO_out}, 64'd0);
    check("abort_busy_done", {62'd0, dut_if.Busy, dut_if.Done}, 64'd0);
    sb.delete();
    m_hi = '0; m_lo = '0; cur_hi = '0; cur_lo = '0; busy_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    issue(4'd1, 32'd7, 32'd6, 1'b0); wait_idle();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd7) op = 4'($urandom_range(8, 15));
      issue(op, rnd_val(), rnd_val(), ($urandom_range(0, 3) == 0));
      wait_idle();
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and HI/LO width (legal values 8..64, even).
REQ-002 The block SHALL have parameter SIGNED_FIX, default 1; 0 removes the signed ops (0000, 0010, 0011, 0100), which are then treated as illegal.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Start, input, 1 bit: operation request, sampled on the rising edge.
REQ-006 Port Op, input, 4 bits: 0000 mult, 0001 multu, 0010 madd, 0011 msub, 0100 div, 0101 divu, 0110 mthi, 0111 mtlo; all other codes are illegal.
REQ-007 Port A, input, WIDTH bits: multiplicand / dividend / mthi-mtlo source.
REQ-008 Port B, input, WIDTH bits: multiplier / divisor.
REQ-009 Port Busy, output, 1 bit: iterative operation in progress.
REQ-010 Port Done, output, 1 bit: one-cycle completion pulse.
REQ-011 Port DivByZero, output, 1 bit: one-cycle pulse, coincident with Done, for div/divu with B==0.
REQ-012 Port HI_out, output, WIDTH bits: architectural HI register.
REQ-013 Port LO_out, output, WIDTH bits: architectural LO register.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE.
REQ-015 Start SHALL be accepted only in IDLE; Start asserted in any other state SHALL be ignored.
REQ-016 When Start is accepted with an illegal Op, the block SHALL remain in IDLE, assert no outputs and leave HI/LO unchanged.
REQ-017 Accepted mthi/mtlo SHALL load A into HI/LO on the accepting edge, pulse Done in the following cycle and never assert Busy.
REQ-018 Accepted mult/multu/madd/msub SHALL latch operand magnitudes (signed ops use absolute values and record the result sign) and enter MUL.
REQ-019 MUL SHALL run one radix-2 shift-add step per cycle for exactly WIDTH cycles, then enter FIX.
REQ-020 Accepted div/divu with B!=0 SHALL enter DIV, run one restoring shift-subtract step per cycle for exactly WIDTH cycles, then enter FIX.
REQ-021 FIX SHALL apply sign correction and, on the FIX->DONE edge, write HI/LO: mult/multu {HI,LO}=A*B; madd {HI,LO}+=A*B; msub {HI,LO}-=A*B; all modulo 2^(2*WIDTH); madd/msub are always signed.
REQ-022 Division results SHALL be LO=quotient truncated toward zero and HI=remainder with the sign of the dividend.
REQ-023 div of -2^(WIDTH-1) by -1 SHALL produce LO=-2^(WIDTH-1), HI=0, with no flag.
REQ-024 div/divu with B==0 SHALL go directly to DONE with HI/LO unchanged and DivByZero pulsed.
REQ-025 Busy SHALL be 1 in MUL, DIV and FIX, and 0 in IDLE and DONE.
REQ-026 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-027 Done SHALL occur WIDTH+2 cycles after the accepting edge for multiply/divide ops.
REQ-028 Start may be re-asserted in the cycle after DONE (back-to-back operation).
REQ-029 HI_out/LO_out SHALL change only on the write edges defined in REQ-017, REQ-021 and REQ-022, and SHALL hold their values otherwise, including throughout Busy.
REQ-030 A and B SHALL be sampled only at acceptance; changes to A/B while Busy SHALL have no effect.

Reset
REQ-031 Reset=0 SHALL, asynchronously: force IDLE; set HI_out=0, LO_out=0, Busy=0, Done=0 and DivByZero=0; clear all iteration registers.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no partial HI/LO write.
REQ-033 After Reset deasserts, the first Start SHALL be accepted on the first rising edge at which Reset=1.

Verification (WIDTH=32)
REQ-034 mult A=2000000000, B=-7 -> Done at cycle 34 after acceptance; HI=0xFFFFFFFC, LO=0xBD88F400; Busy high for cycles 1..33.
REQ-035 mthi 12, mtlo 1, then madd A=3, B=-4 -> HI=11, LO=0xFFFFFFF5; repeating the mthi/mtlo preload then msub A=3, B=4 -> HI=11, LO=0xFFFFFFF5.
REQ-036 div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=0xFFFFFFFF, B=16 -> LO=0x0FFFFFFF, HI=0xF.
REQ-037 div A=5, B=0 with HI=0xAA, LO=0xBB -> Done and DivByZero pulse one cycle after acceptance; HI/LO remain 0xAA/0xBB.
REQ-038 Start mult mid-operation ignored; A/B changed while Busy ignored; Reset pulsed at cycle 10 of a mult -> HI=LO=0, Busy=0 immediately; no Done.
REQ-039 Illegal Op 1111 with Start -> no Busy, no Done, HI/LO unchanged; a back-to-back mult issued the cycle after a Done is accepted.
